adder_slice_sched: RTL and testbench
====================================

# adder_slice_sched

Multi-cycle scheduler that shares one external 4-bit ripple-carry adder slice (a, b, cin → sum, cout) between two requesters. It performs WIDTH-bit additions by feeding operands through the slice one nibble per cycle, LSB first, and chains the carry in a register. It sits between client datapaths and a swappable exact or approximate adder partition, so slice accuracy can be evaluated at full word width.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4, ≥ 4; N = WIDTH/4 nibble steps
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_cin  in  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that owns the result
- resp_sum  out  WIDTH  sum
- resp_cout  out  1  final carry-out
- resp_err  out  1  result differed from exact sum (see Configuration)
- err_count  out  16  saturating mismatch counter (see Configuration)
- slice_a, slice_b  out  4  nibble to slice
- slice_cin  out  1  carry to slice
- slice_sum  in  4  slice sum (combinational from slice_*)
- slice_cout  in  1  slice carry-out

## Operation
- States: IDLE, RUN, DONE.
- IDLE: reqX_ready is combinational. It is high only for the arbitration winner, and only when that requester's valid is high. With one valid, that requester wins. With both valid, the requester not granted last wins. The last-grant pointer resets to 1, so req0 wins the first tie.
- Acceptance (valid & ready): latch a, b and cin; latch id into resp_id; update the last-grant pointer; clear step k to 0; go to RUN.
- RUN, step k:
  - slice_a = a[4k+3:4k], slice_b = b[4k+3:4k].
  - slice_cin = latched cin when k = 0, else the carry register.
  - On each edge: resp_sum nibble k ← slice_sum; carry register ← slice_cout; k ← k+1.
  - After step N−1: resp_cout ← slice_cout; go to DONE.
- DONE: resp_valid = 1. resp_id, resp_sum, resp_cout and resp_err are stable until resp_valid & resp_ready, then return to IDLE.
- Neither requester is accepted in RUN or DONE: both readys are 0.
- Outside RUN, slice_a, slice_b and slice_cin are driven to 0.
- Arithmetic is modulo 2^WIDTH. Overflow is reported only through resp_cout.
- Reset, asynchronous and effective at any time including mid-RUN:
  - aborts the operation, state → IDLE, k = 0, carry register = 0, last-grant pointer = 1;
  - every output → 0: readys, resp_valid, resp_id, resp_sum, resp_cout, resp_err, err_count, slice_*.
  - An aborted operation produces no response.

## Timing
- Acceptance edge t. RUN occupies edges t+1 … t+N. resp_valid is high from after edge t+N.
- Latency from acceptance to resp_valid is N cycles (4 for WIDTH=16).
- Minimum cycle-to-cycle spacing between acceptances is N+2 (resp_ready held high).
- resp_ready low stalls in DONE indefinitely, and the outputs hold.
- Requester operands are sampled only at the acceptance edge. Later changes are ignored.
- The slice path is combinational within one cycle (slice_* → slice_sum → register). There are no multicycle paths.

## Configuration
- ADDER_SCHED_ERRCNT_EN defined:
  - latch an exact WIDTH+1-bit sum of a + b + cin at acceptance;
  - on entering DONE, resp_err = ({resp_cout, resp_sum} ≠ exact);
  - err_count increments by 1 on each DONE entry with a mismatch and saturates at 0xFFFF. It is cleared only by rst.
- Not defined: resp_err and err_count are tied to 0, and no exact adder or storage is instantiated.

## Test plan
- Exact slice, WIDTH=16: req0 a=0x1234, b=0x4321, cin=0 → after 4 cycles resp_valid=1, resp_sum=0x5555, resp_cout=0, resp_id=0.
- Carry ripple: req1 a=0xFFFF, b=0x0000, cin=1 → resp_sum=0x0000, resp_cout=1, resp_id=1. slice_cin is 1 at every step.
- Simultaneous req0 and req1 valid from reset:
  - req0 is accepted first; req1 is accepted in the first IDLE cycle after req0's response handshake.
  - With both valid again afterwards, req0 wins, because the pointer now favours the requester not last granted.
- Backpressure: resp_ready=0 for 10 cycles in DONE → outputs stable and both readys 0; resp_ready=1 → IDLE next cycle.
- rst pulse at RUN step 2 → all outputs 0 immediately, no resp_valid; next request completes correctly.
- With ADDER_SCHED_ERRCNT_EN and a slice model forcing sum bit0=0: a=0x0001, b=0x0000 → resp_sum=0x0000, resp_err=1, err_count=1. Then a=0x0002, b=0x0000 → resp_err=0, err_count stays 1.

Source files
------------

// File: rtl/adder_slice_sched.sv
`default_nettype none
// ============================================================================
// Module      : adder_slice_sched
// Description : Time-shares one external 4-bit adder slice between two
//               requesters, building WIDTH-bit sums one nibble per cycle.
//               Optional macro ADDER_SCHED_ERRCNT_EN adds an exact reference
//               sum, per-result mismatch flag and saturating error counter.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_slice_sched #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_err,
  output logic [15:0]      err_count,
  output logic [3:0]       slice_a,
  output logic [3:0]       slice_b,
  output logic             slice_cin,
  input  logic [3:0]       slice_sum,
  input  logic             slice_cout
);

  localparam int c_n  = WIDTH / 4;
  localparam int c_kw = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_kw-1:0] c_klast = c_kw'(c_n - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [c_kw-1:0]  r_k;
  logic             r_last;
  logic             r_cin;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_sh;
  logic [WIDTH-1:0] w_b_sh;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_sel_cin;
  logic             w_take0;
  logic             w_take1;
  logic             w_accept;
  logic             w_last_step;

  // r_last holds the id granted most recently; a tie goes to the other one
  assign w_take0 = (r_state == c_idle) & ~rst & req0_valid & (~req1_valid | r_last);
  assign w_take1 = (r_state == c_idle) & ~rst & req1_valid & (~req0_valid | ~r_last);
  assign w_accept    = w_take0 | w_take1;
  assign w_last_step = (r_state == c_run) & (r_k == c_klast);

  assign w_sel_a   = w_take1 ? req1_a   : req0_a;
  assign w_sel_b   = w_take1 ? req1_b   : req0_b;
  assign w_sel_cin = w_take1 ? req1_cin : req0_cin;

  assign w_a_sh = r_a >> {r_k, 2'b00};
  assign w_b_sh = r_b >> {r_k, 2'b00};

  always_comb begin
    w_sum_next = resp_sum;
    w_sum_next[{r_k, 2'b00} +: 4] = slice_sum;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_idle:  if (w_accept)    w_next = c_run;
      c_run:   if (w_last_step) w_next = c_done;
      c_done:  if (resp_ready)  w_next = c_idle;
      default: w_next = c_idle;
    endcase
  end

  // Output logic
  always_comb begin
    req0_ready = w_take0;
    req1_ready = w_take1;
    resp_valid = (r_state == c_done);
    slice_a    = 4'd0;
    slice_b    = 4'd0;
    slice_cin  = 1'b0;
    if (r_state == c_run) begin
      slice_a   = w_a_sh[3:0];
      slice_b   = w_b_sh[3:0];
      slice_cin = (r_k == '0) ? r_cin : r_carry;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_cin     <= 1'b0;
      r_carry   <= 1'b0;
      r_k       <= '0;
      r_last    <= 1'b1;
      resp_id   <= 1'b0;
      resp_sum  <= '0;
      resp_cout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= w_sel_a;
        r_b     <= w_sel_b;
        r_cin   <= w_sel_cin;
        r_k     <= '0;
        r_last  <= w_take1;
        resp_id <= w_take1;
      end
      if (r_state == c_run) begin
        resp_sum <= w_sum_next;
        r_carry  <= slice_cout;
        r_k      <= w_last_step ? '0 : r_k + c_kw'(1);
        if (w_last_step) begin
          resp_cout <= slice_cout;
        end
      end
    end
  end

`ifdef ADDER_SCHED_ERRCNT_EN
  logic [WIDTH:0] r_exact;
  logic           r_err;
  logic [15:0]    r_err_count;
  logic           w_mismatch;

  assign w_mismatch = ({slice_cout, w_sum_next} != r_exact);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exact     <= '0;
      r_err       <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_accept) begin
        r_exact <= {1'b0, w_sel_a} + {1'b0, w_sel_b} + {{WIDTH{1'b0}}, w_sel_cin};
      end
      if (w_last_step) begin
        r_err <= w_mismatch;
        if (w_mismatch && (r_err_count != 16'hFFFF)) begin
          r_err_count <= r_err_count + 16'd1;
        end
      end
    end
  end

  assign resp_err  = r_err;
  assign err_count = r_err_count;
`else
  assign resp_err  = 1'b0;
  assign err_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_slice_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_slice_sched
// Description : Directed self-checking bench for adder_slice_sched (WIDTH=16)
//               driving a behavioural slice with an optional bit0 fault.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_slice_sched;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
  logic         resp_valid, resp_id, resp_cout, resp_err;
  logic         resp_ready = 1'b1;
  logic [W-1:0] resp_sum;
  logic [15:0]  err_count;
  logic [3:0]   slice_a, slice_b, slice_sum;
  logic         slice_cin, slice_cout;
  logic         slice_bug = 1'b0;
  logic [4:0]   w_full;

  int total = 0;
  int bad   = 0;

`ifdef ADDER_SCHED_ERRCNT_EN
  localparam logic c_err_on = 1'b1;
`else
  localparam logic c_err_on = 1'b0;
`endif

  assign w_full     = {1'b0, slice_a} + {1'b0, slice_b} + {4'd0, slice_cin};
  assign slice_sum  = w_full[3:0] & {3'b111, ~slice_bug};
  assign slice_cout = w_full[4];

  always #5 clk = ~clk;

  adder_slice_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_cin(req1_cin),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_sum(resp_sum), .resp_cout(resp_cout), .resp_err(resp_err),
    .err_count(err_count),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Waits (bounded) for resp_valid and checks the acceptance-to-valid latency.
  task automatic wait_resp(input string tag);
    int n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk(tag, n, 4);
  endtask

  task automatic check_resp(input string tag, input logic [W-1:0] s, input logic c,
                            input logic id, input logic e);
    chk({tag, "_sum"},  resp_sum, s);
    chk({tag, "_cout"}, resp_cout, c);
    chk({tag, "_id"},   resp_id, id);
    chk({tag, "_err"},  resp_err, e);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdy0", req0_ready, 0);
    chk("rst_sum", resp_sum, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_slice_a", slice_a, 0);
    tick();
    rst = 1'b0;

    // req0 only: 0x1234 + 0x4321
    req0_a = 16'h1234; req0_b = 16'h4321; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t1_slice_a0", slice_a, 4'h4);
    chk("t1_slice_b0", slice_b, 4'h1);
    chk("t1_run_rdy0", req0_ready, 0);
    wait_resp("t1_lat");
    check_resp("t1", 16'h5555, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t1_idle_valid", resp_valid, 0);
    chk("t1_idle_slice", slice_a, 0);

    // req1 only: carry ripples through all four nibbles
    req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t2_rdy1", req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_cin%0d", i), slice_cin, 1);
      chk($sformatf("t2_sa%0d", i), slice_a, 4'hF);
      chk($sformatf("t2_valid%0d", i), resp_valid, 0);
      tick();
    end
    chk("t2_valid", resp_valid, 1);
    check_resp("t2", 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();

    // Fresh reset, then both requesters valid together
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_a = 16'h0011; req0_b = 16'h0022; req0_cin = 1'b0; req0_valid = 1'b1;
    req1_a = 16'h8000; req1_b = 16'h8000; req1_cin = 1'b0; req1_valid = 1'b1;
    #1;
    chk("t3_rdy0", req0_ready, 1);
    chk("t3_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t3_run_rdy1", req1_ready, 0);
    wait_resp("t3_lat0");
    check_resp("t3a", 16'h0033, 1'b0, 1'b0, 1'b0);
    chk("t3_done_rdy1", req1_ready, 0);
    tick();
    chk("t3_idle_rdy1", req1_ready, 1);
    resp_ready = 1'b0;
    tick();
    req1_valid = 1'b0;
    wait_resp("t3_lat1");
    check_resp("t3b", 16'h0000, 1'b1, 1'b1, 1'b0);

    // Backpressure with both requesters waiting
    req0_a = 16'h0F0F; req0_b = 16'h0101; req0_cin = 1'b1; req0_valid = 1'b1;
    req1_a = 16'h1111; req1_b = 16'h1111; req1_cin = 1'b0; req1_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp_valid%0d", i), resp_valid, 1);
      chk($sformatf("bp_sum%0d", i), resp_sum, 16'h0000);
      chk($sformatf("bp_rdy%0d", i), {req0_ready, req1_ready}, 2'b00);
    end
    check_resp("bp", 16'h0000, 1'b1, 1'b1, 1'b0);
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_valid", resp_valid, 0);
    chk("t3_tie_rdy0", req0_ready, 1);
    chk("t3_tie_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_resp("t3_lat2");
    check_resp("t3c", 16'h1011, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset at RUN step 2 aborts the operation
    req1_a = 16'h00FF; req1_b = 16'h0001; req1_cin = 1'b0; req1_valid = 1'b1;
    tick();
    req1_valid = 1'b0;
    tick();
    tick();
    chk("ab_step2_sa", slice_a, 4'h0);
    chk("ab_step2_cin", slice_cin, 1);
    rst = 1'b1;
    #1;
    chk("ab_sum", resp_sum, 0);
    chk("ab_id", resp_id, 0);
    chk("ab_cin", slice_cin, 0);
    chk("ab_valid", resp_valid, 0);
    #2;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("ab_novalid%0d", i), resp_valid, 0);
    end
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b0; req0_valid = 1'b1;
    #1;
    chk("ab_next_rdy0", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    wait_resp("ab_lat");
    check_resp("ab_next", 16'h8000, 1'b0, 1'b0, 1'b0);
    tick();

    // Faulty slice: sum bit0 stuck at 0
    slice_bug = 1'b1;
    req0_a = 16'h0001; req0_b = 16'h0000; req0_cin = 1'b0; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    wait_resp("f1_lat");
    check_resp("f1", 16'h0000, 1'b0, 1'b0, c_err_on);
    chk("f1_errcnt", err_count, {15'd0, c_err_on});
    tick();
    req0_a = 16'h0002; req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    wait_resp("f2_lat");
    check_resp("f2", 16'h0002, 1'b0, 1'b0, 1'b0);
    chk("f2_errcnt", err_count, {15'd0, c_err_on});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
